pwm_clkgen: RTL and testbench

- Synthesizable, parametrised multi-channel clock/PWM generator.
- Each channel produces a waveform with programmable period, high time and phase offset, all counted in cycles of clk.
- All enabled channels launch together on a shared start pulse.
- Serves as the stimulus/clock source block for sub-rate clocks and phase-shifted strobes in the verification and demo tops.

---
 rtl/pwm_clkgen_pkg.sv | 27 ++
 rtl/pwm_clkgen_if.sv | 27 ++
 rtl/pwm_clkgen_ch.sv | 101 ++++++++++
 rtl/pwm_clkgen.sv | 70 +++++++
 tb/tb_pwm_clkgen.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_clkgen_pkg.sv
// Shared types for the multi-channel PWM / clock generator: channel FSM states,
// the per-channel configuration record and the channel-index width helper.
package pwm_clkgen_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  function automatic int calc_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_DEF = calc_ch_w(N_CH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_RUN   = 2'd2
  } ch_state_e;

  // Field width is fixed here; instances must use CNT_W == CNT_W_DEF.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] ton;
    logic [CNT_W_DEF-1:0] phase;
  } ch_cfg_t;

endpackage

// File: rtl/pwm_clkgen_if.sv
// Configuration write bus of pwm_clkgen: valid/ready handshake plus a
// one-cycle error pulse for rejected writes.
interface pwm_clkgen_if #(
  parameter int N_CH  = pwm_clkgen_pkg::N_CH_DEF,
  parameter int CNT_W = pwm_clkgen_pkg::CNT_W_DEF
);
  localparam int CH_W = pwm_clkgen_pkg::calc_ch_w(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_ton;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_ton, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_ton, cfg_phase,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/pwm_clkgen_ch.sv
// One PWM channel: config registers, IDLE/PHASE/RUN sequencer, cycle counter
// and the registered waveform output.
module pwm_clkgen_ch
  import pwm_clkgen_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  input  logic    stop,
  input  logic    en,
  input  logic    cfg_we,
  input  ch_cfg_t cfg_wdata,
  output logic    clk_out,
  output logic    active
);

  localparam int W = CNT_W_DEF;

  ch_cfg_t      cfg_q;
  ch_state_e    state_q;
  ch_state_e    state_d;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         clk_out_q;
  logic         active_q;

  logic         launch;
  logic         period_last;

  // A channel whose period is still 0 (never configured since reset) ignores start.
  assign launch      = start && en && (cfg_q.period != '0);
  assign period_last = (cnt_q == (cfg_q.period - W'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (launch) begin
            if (cfg_q.phase == '0) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              state_d = ST_PHASE;
              cnt_d   = cfg_q.phase;
            end
          end
        end
        ST_PHASE: begin
          if (cnt_q == W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        ST_RUN: begin
          // Disable only takes effect at the period boundary so the last cycle completes.
          if (period_last) begin
            cnt_d = '0;
            if (!en) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      if (cfg_we) begin
        cfg_q <= cfg_wdata;
      end
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= (state_d == ST_RUN) && (cnt_d < cfg_q.ton);
      active_q  <= (state_d != ST_IDLE);
    end
  end

  assign clk_out = clk_out_q;
  assign active  = active_q;

endmodule

// File: rtl/pwm_clkgen.sv
// Multi-channel PWM / clock generator: per-channel waveforms with programmable
// period, high time and phase, launched together by a shared start pulse.
module pwm_clkgen
  import pwm_clkgen_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_clkgen_if.slave      cfg_if,
  input  logic             start,
  input  logic             stop,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  active
);

  localparam int CH_W = calc_ch_w(N_CH);

  logic [N_CH-1:0] ch_sel;
  logic [N_CH-1:0] ch_we;
  logic            ch_in_range;
  logic            cfg_accept;
  logic            cfg_bad;
  logic            cfg_err_q;
  ch_cfg_t         cfg_wdata;

  // An out-of-range index selects no channel, which makes ready 1 and flags the write bad.
  assign ch_in_range = |ch_sel;
  assign cfg_if.cfg_ready = ~|(ch_sel & active);
  assign cfg_accept  = cfg_if.cfg_valid && cfg_if.cfg_ready;
  assign cfg_bad     = !ch_in_range
                    || (cfg_if.cfg_period == '0)
                    || (cfg_if.cfg_ton > cfg_if.cfg_period);

  assign cfg_wdata.period = cfg_if.cfg_period;
  assign cfg_wdata.ton    = cfg_if.cfg_ton;
  assign cfg_wdata.phase  = cfg_if.cfg_phase;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_sel[gi] = (cfg_if.cfg_ch == CH_W'(gi));
      assign ch_we[gi]  = cfg_accept && !cfg_bad && ch_sel[gi];

      pwm_clkgen_ch u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .en        (ch_en[gi]),
        .cfg_we    (ch_we[gi]),
        .cfg_wdata (cfg_wdata),
        .clk_out   (clk_out[gi]),
        .active    (active[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_accept && cfg_bad;
    end
  end

  assign cfg_if.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pwm_clkgen.sv
// Self-checking bench for pwm_clkgen: directed scenarios plus random traffic,
// all compared against a waveform-level reference model.
module tb_pwm_clkgen;
  import pwm_clkgen_pkg::*;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int CW = calc_ch_w(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [N-1:0] ch_en = '0;
  logic [N-1:0] clk_out;
  logic [N-1:0] active;

  pwm_clkgen_if #(.N_CH(N), .CNT_W(W)) cif ();

  pwm_clkgen #(.N_CH(N), .CNT_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_if  (cif),
    .start   (start),
    .stop    (stop),
    .ch_en   (ch_en),
    .clk_out (clk_out),
    .active  (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a running channel launched at edge S is high after edge t
  // when k = t - S - phase >= 0 and (k mod period) < ton.
  int           m_per[N];
  int           m_ton[N];
  int           m_ph[N];
  int           m_S[N];
  bit           m_run[N];
  logic [N-1:0] exp_clk;
  logic [N-1:0] exp_act;
  logic         exp_err;

  function automatic bit m_ready(input int ch);
    if (ch >= N) return 1'b1;
    return !m_run[ch];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_per[i] = 0; m_ton[i] = 0; m_ph[i] = 0; m_S[i] = 0; m_run[i] = 0;
    end
    exp_clk = '0; exp_act = '0; exp_err = 1'b0;
  endtask

  task automatic tick();
    bit s, p, v, acc, bad;
    logic [N-1:0] e;
    int ch, per, ton, ph, k;
    s = start; p = stop; e = ch_en; v = cif.cfg_valid;
    ch = int'(cif.cfg_ch); per = int'(cif.cfg_period);
    ton = int'(cif.cfg_ton); ph = int'(cif.cfg_phase);
    acc = v && m_ready(ch);
    bad = (ch >= N) || (per == 0) || (ton > per);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (p) begin
          m_run[i] = 0;
        end else if (!m_run[i]) begin
          if (s && e[i] && m_per[i] != 0) begin
            m_run[i] = 1; m_S[i] = cyc;
          end
        end else begin
          k = cyc - 1 - m_S[i] - m_ph[i];
          if (k >= 0 && (k % m_per[i]) == m_per[i] - 1 && !e[i]) m_run[i] = 0;
        end
      end
      if (acc && !bad) begin
        m_per[ch] = per; m_ton[ch] = ton; m_ph[ch] = ph;
      end
      exp_err = acc && bad;
      for (int i = 0; i < N; i++) begin
        exp_act[i] = m_run[i];
        exp_clk[i] = 1'b0;
        if (m_run[i]) begin
          k = cyc - m_S[i] - m_ph[i];
          if (k >= 0) exp_clk[i] = ((k % m_per[i]) < m_ton[i]);
        end
      end
    end
    #1;
  endtask

  task automatic cfg_write(input int ch, input int per, input int ton, input int ph);
    cif.cfg_valid = 1'b1; cif.cfg_ch = CW'(ch);
    cif.cfg_period = W'(per); cif.cfg_ton = W'(ton); cif.cfg_phase = W'(ph);
    tick();
    cif.cfg_valid = 1'b0;
  endtask

  task automatic halt_all();
    stop = 1'b1; tick(); stop = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (clk_out !== '0) $display("FAIL reset_clk_out: got %b expected 000", clk_out);
    if (clk_out !== '0) failures++;
    checks++; if (active !== '0) begin failures++; $display("FAIL reset_active: got %b expected 000", active); end
    checks++; if (cif.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %b expected 0", cif.cfg_err); end
    checks++; if (cif.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready: got %b expected 1", cif.cfg_ready); end
  endtask

  task automatic test_single();
    int s_edge;
    int hits[$];
    cfg_write(0, 10, 1, 0);
    ch_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    s_edge = cyc;
    checks++; if (active[0] !== 1'b1) begin failures++; $display("FAIL single_active_first: got %b expected 1", active[0]); end
    for (int c = 0; c < 30; c++) begin
      checks++; if (clk_out !== exp_clk) begin failures++; $display("FAIL single_clk cyc=%0d: got %b expected %b", cyc, clk_out, exp_clk); end
      if (clk_out[0] === 1'b1) hits.push_back(cyc - s_edge);
      tick();
    end
    checks++;
    if (hits.size() != 3 || hits[0] != 0 || hits[1] != 10 || hits[2] != 20) begin
      failures++; $display("FAIL single_high_edges: got %0d highs (first at +%0d) expected 3 at +0,+10,+20",
                           hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
    halt_all();
  endtask

  task automatic test_two_phase();
    int r0[$];
    int r1[$];
    logic [N-1:0] prev;
    cfg_write(0, 8, 4, 0);
    cfg_write(1, 8, 4, 2);
    ch_en = 3'b011; start = 1'b1; tick(); start = 1'b0;
    prev = '0;
    for (int c = 0; c < 80; c++) begin
      checks++; if (clk_out !== exp_clk) begin failures++; $display("FAIL two_phase_clk cyc=%0d: got %b expected %b", cyc, clk_out, exp_clk); end
      if (clk_out[0] === 1'b1 && prev[0] === 1'b0) r0.push_back(cyc);
      if (clk_out[1] === 1'b1 && prev[1] === 1'b0) r1.push_back(cyc);
      prev = clk_out;
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (j >= r0.size() || j >= r1.size() || (r1[j] - r0[j]) != 2) begin
        failures++; $display("FAIL two_phase_align period=%0d: got rises %0d/%0d expected offset 2", j, r0.size(), r1.size());
      end
    end
    halt_all();
  endtask

  task automatic test_errors();
    int highs;
    cfg_write(0, 10, 3, 0);
    cfg_write(0, 10, 12, 0);
    checks++; if (cif.cfg_err !== 1'b1) begin failures++; $display("FAIL err_ton_gt_period: got %b expected 1", cif.cfg_err); end
    tick();
    checks++; if (cif.cfg_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b expected 0", cif.cfg_err); end
    ch_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      if (clk_out[0] === 1'b1) highs++;
      tick();
    end
    checks++; if (highs != 3) begin failures++; $display("FAIL err_regs_unchanged: got %0d high cycles expected 3", highs); end
    halt_all();
    cif.cfg_valid = 1'b1; cif.cfg_ch = CW'(N); cif.cfg_period = 16'd5; cif.cfg_ton = 16'd2; cif.cfg_phase = 16'd0;
    #1;
    checks++; if (cif.cfg_ready !== 1'b1) begin failures++; $display("FAIL err_bad_ch_ready: got %b expected 1", cif.cfg_ready); end
    tick(); cif.cfg_valid = 1'b0;
    checks++; if (cif.cfg_err !== 1'b1) begin failures++; $display("FAIL err_bad_ch: got %b expected 1", cif.cfg_err); end
    cfg_write(1, 0, 0, 0);
    checks++; if (cif.cfg_err !== 1'b1) begin failures++; $display("FAIL err_period_zero: got %b expected 1", cif.cfg_err); end
    tick();
  endtask

  task automatic test_gating();
    cfg_write(0, 10, 4, 1);
    ch_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    cif.cfg_valid = 1'b1; cif.cfg_ch = CW'(0); cif.cfg_period = 16'd6; cif.cfg_ton = 16'd2; cif.cfg_phase = 16'd0;
    #1;
    checks++; if (cif.cfg_ready !== 1'b0) begin failures++; $display("FAIL gate_ready_active: got %b expected 0", cif.cfg_ready); end
    tick(); cif.cfg_valid = 1'b0;
    checks++; if (cif.cfg_err !== 1'b0) begin failures++; $display("FAIL gate_no_err: got %b expected 0", cif.cfg_err); end
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      checks++; if (clk_out !== exp_clk || active !== exp_act) begin
        failures++; $display("FAIL gate_waveform cyc=%0d: got clk=%b act=%b expected clk=%b act=%b", cyc, clk_out, active, exp_clk, exp_act);
      end
      tick();
    end
    halt_all();
  endtask

  task automatic test_enable_stop();
    int s_edge;
    cfg_write(0, 10, 2, 0);
    ch_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    s_edge = cyc;
    repeat (3) tick();
    ch_en = 3'b000;
    for (int c = 0; c < 14; c++) begin
      checks++; if (clk_out !== exp_clk || active !== exp_act) begin
        failures++; $display("FAIL en_drop cyc=%0d: got clk=%b act=%b expected clk=%b act=%b", cyc, clk_out, active, exp_clk, exp_act);
      end
      if (cyc == s_edge + 9) begin
        checks++; if (active[0] !== 1'b1) begin failures++; $display("FAIL en_drop_last_cnt: got %b expected 1", active[0]); end
      end
      if (cyc == s_edge + 10) begin
        checks++; if (active[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
          failures++; $display("FAIL en_drop_idle: got act=%b clk=%b expected 0/0", active[0], clk_out[0]);
        end
      end
      tick();
    end
    cfg_write(1, 8, 4, 2);
    ch_en = 3'b111; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (active !== 3'b000 || clk_out !== 3'b000) begin
        failures++; $display("FAIL stop_and_start: got act=%b clk=%b expected 000/000", active, clk_out);
      end
      tick();
    end
  endtask

  task automatic test_corners();
    int s_edge;
    cfg_write(0, 6, 0, 0);
    cfg_write(1, 6, 6, 1);
    ch_en = 3'b011; start = 1'b1; tick(); start = 1'b0;
    s_edge = cyc;
    for (int c = 0; c < 20; c++) begin
      checks++; if (clk_out[0] !== 1'b0) begin failures++; $display("FAIL ton_zero cyc=%0d: got %b expected 0", cyc, clk_out[0]); end
      if (cyc >= s_edge + 1) begin
        checks++; if (clk_out[1] !== 1'b1) begin failures++; $display("FAIL ton_full cyc=%0d: got %b expected 1", cyc, clk_out[1]); end
      end
      tick();
    end
    halt_all();
  endtask

  task automatic test_random();
    int idx, per, ton;
    ch_en = 3'b111;
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 29) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        ch_en[idx] = ~ch_en[idx];
      end
      if (!start && $urandom_range(0, 4) == 0) begin
        per = int'($urandom_range(0, 12));
        ton = int'($urandom_range(0, per + 1));
        cif.cfg_valid = 1'b1; cif.cfg_ch = CW'($urandom_range(0, 3));
        cif.cfg_period = W'(per); cif.cfg_ton = W'(ton); cif.cfg_phase = W'($urandom_range(0, 4));
      end else begin
        cif.cfg_valid = 1'b0;
      end
      #1;
      checks++; if (cif.cfg_ready !== m_ready(int'(cif.cfg_ch))) begin
        failures++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, cif.cfg_ready, m_ready(int'(cif.cfg_ch)));
      end
      tick();
      checks++; if (clk_out !== exp_clk) begin failures++; $display("FAIL rand_clk cyc=%0d: got %b expected %b", cyc, clk_out, exp_clk); end
      checks++; if (active !== exp_act) begin failures++; $display("FAIL rand_active cyc=%0d: got %b expected %b", cyc, active, exp_act); end
      checks++; if (cif.cfg_err !== exp_err) begin failures++; $display("FAIL rand_err cyc=%0d: got %b expected %b", cyc, cif.cfg_err, exp_err); end
    end
    start = 1'b0; stop = 1'b0; cif.cfg_valid = 1'b0;
    halt_all();
  endtask

  task automatic test_reset_mid();
    cfg_write(0, 5, 3, 0);
    ch_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    checks++; if (active[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_running: got %b expected 1", active[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (clk_out !== '0 || active !== '0) begin
      failures++; $display("FAIL rst_mid_async: got clk=%b act=%b expected 000/000", clk_out, active);
    end
    model_clear();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (active !== '0 || clk_out !== '0) begin
        failures++; $display("FAIL rst_cfg_lost: got clk=%b act=%b expected 000/000", clk_out, active);
      end
      tick();
    end
    cfg_write(0, 4, 2, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++; if (clk_out !== exp_clk || active !== exp_act) begin
        failures++; $display("FAIL rst_relaunch cyc=%0d: got clk=%b act=%b expected clk=%b act=%b", cyc, clk_out, active, exp_clk, exp_act);
      end
      tick();
    end
  endtask

  initial begin
    cif.cfg_valid = 1'b0; cif.cfg_ch = '0;
    cif.cfg_period = '0; cif.cfg_ton = '0; cif.cfg_phase = '0;
    model_clear();
    test_reset();
    test_single();
    test_two_phase();
    test_errors();
    test_gating();
    test_enable_stop();
    test_corners();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
